carregador_programa: RTL
========================

# carregador_programa

Loads a process image from the simulated HD into that process's partition of the instruction memory. It is the writer side of the instruction-memory port: it drives `InstrWrite`, address and data, which the fetch path only reads. It is triggered by the OS controller before a process is first scheduled. It reads one HD track sector by sector and writes each word into the partition selected by `id_proc`, using the same base-plus-partition mapping as the fetch path.

## Interface

Parameters:
- `BASE_MI`, 20, first instruction-memory address of process partitions (same offset as fetch mapping)
- `TAM_PARTICAO`, 50, words per process partition
- `MAX_SETOR`, 64, sectors per HD track

Ports:
- `clk`  in  1  system clock (the divided 1 Hz `clk` domain); single clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  level, sampled on rising `clk`; starts a load when idle
- `id_proc`  in  2  target process, 1..3; 0 (OS) is rejected
- `trilha`  in  4  HD track holding the image
- `num_palavras`  in  6  words to copy, 0..63
- `hd_trilha`  out  4  track address to HD
- `hd_setor`  out  6  sector address to HD
- `hd_dado`  in  32  HD read data
- `mi_ender`  out  9  instruction-memory write address
- `mi_dado`  out  32  instruction-memory write data
- `InstrWrite`  out  1  instruction-memory write strobe
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle completion pulse
- `erro`  out  1  valid with `done`; high when the request was rejected

## Operation

- States:
  - OCIOSO: idle.
  - ENDERECA: `hd_setor` holds the current index.
  - ESCREVE: `InstrWrite` = 1.
  - FIM: `done` = 1.
- OCIOSO, `start` = 1:
  - Latch `id_proc`, `trilha` and n = min(`num_palavras`, `TAM_PARTICAO`).
  - Clear the index.
  - If latched id = 0, go to FIM with `erro` = 1.
  - Else if n = 0, go to FIM with `erro` = 0.
  - Else go to ENDERECA.
- ENDERECA → ESCREVE unconditionally.
- In ESCREVE:
  - `mi_dado` = `hd_dado`; `mi_ender` = `BASE_MI` + id·`TAM_PARTICAO` + index, with the arithmetic done in 9 bits. The maximum is 20+150+49 = 219, so there is no overflow.
  - If index = n−1, go to FIM; else increment the index and go to ENDERECA.
- FIM → OCIOSO unconditionally. `erro` holds its value only while `done` = 1 and reads 0 otherwise.
- `start` is ignored outside OCIOSO. The latched inputs are immune to changes on the input pins mid-load.
- `start` held high: a new load begins on the cycle after FIM (back-to-back loads allowed).
- The index never exceeds 49, so `hd_setor` never wraps.
- `hd_trilha` = latched track while `busy`, otherwise 0.

## Timing

- Reset values:
  - State OCIOSO.
  - `InstrWrite`, `busy`, `done`, `erro` = 0.
  - `hd_trilha`, `hd_setor`, `mi_ender`, `mi_dado` = 0.
- Reset mid-load deasserts `InstrWrite` immediately, because reset is asynchronous. Words already written stay written; no `done` is issued.
- The HD read port is combinational relative to `clk`: it is clocked by the fast clock, so `hd_dado` is valid within the same `clk` cycle as the address. The address is held for the whole ENDERECA and ESCREVE pair, so the data is stable at the write edge.
- All outputs are registered (Moore).
- Load accepted at edge k:
  - `busy` is high from cycle k+1 through k+2n.
  - The word i write occupies cycle k+2+2i.
  - `done` is high in cycle k+2n+1.
  - Total latency is 2n+1 cycles.
- Rejected or n = 0 request: `done` is high in cycle k+1, and `busy` is never asserted.
- `InstrWrite` is never high in two consecutive cycles.

## Structure

- Shared package (the one holding the memory map):
  - State encoding, 2 bits.
  - `BASE_MI` = 20, `TAM_PARTICAO` = 50, and the data-memory offset 150.
- One sub-module: `soma_endereco_proc`, instanced with M = `BASE_MI` and `tam_particao` = `TAM_PARTICAO`. Using it keeps the load mapping bit-identical to the fetch mapping.
- The rest is a single FSM plus a 6-bit index counter: 150–250 lines.

## Test plan

- Load id = 1, trilha = 3, n = 4, with the HD model returning 32'hA000_0000+setor:
  - Writes to addresses 70..73 with data A000_0000..A000_0003.
  - `done` arrives 9 cycles after `start`, with `erro` = 0.
- Load id = 3, n = 63:
  - Clamped to 50 writes, at 170..219.
  - `done` at cycle 101; no write outside the partition.
- id = 0, n = 5: `done` and `erro` in the next cycle; zero `InstrWrite` pulses; `busy` stays 0.
- n = 0, id = 2: `done` = 1 with `erro` = 0 after 1 cycle; no writes.
- `reset` pulsed during the third ESCREVE of an n = 10 load:
  - `InstrWrite` drops asynchronously; all outputs return to reset values.
  - A following load with n = 2 completes normally in 5 cycles.
- `start` toggled and `id_proc`/`trilha` changed mid-load: these changes have no effect. With `start` held high, the second load begins in the cycle after `done`.

Source files
------------

// File: rtl/carregador_programa_pkg.sv
// carregador_programa_pkg
//   Shared memory map and FSM state encoding for the program loader.
//   BASE_MI/TAM_PARTICAO are the same constants the fetch path uses for
//   its partition mapping; BASE_MD is the data-memory offset.
package carregador_programa_pkg;

    localparam int unsigned BASE_MI      = 20;
    localparam int unsigned TAM_PARTICAO = 50;
    localparam int unsigned BASE_MD      = 150;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ENDERECA = 2'd1,
        ESCREVE  = 2'd2,
        FIM      = 2'd3
    } estado_t;

endpackage

// File: rtl/soma_endereco_proc.sv
// soma_endereco_proc
//   Process partition address: M + id * tam_particao + offset, in 9 bits.
//   Shared with the fetch path so both use a bit-identical mapping.
// Ports:
//   i_id       - process id (0..3)
//   i_offset   - word offset inside the partition
//   o_endereco - resulting instruction-memory address
module soma_endereco_proc #(
    parameter int unsigned M            = 20,
    parameter int unsigned tam_particao = 50
) (
    input  logic [1:0] i_id,
    input  logic [5:0] i_offset,
    output logic [8:0] o_endereco
);

    assign o_endereco = 9'(M) + 9'(i_id) * 9'(tam_particao) + 9'(i_offset);

endmodule

// File: rtl/carregador_programa.sv
// carregador_programa
//   Copies a process image from one HD track into that process's partition
//   of the instruction memory, one word every two clk cycles.
// Ports:
//   clk, reset          - clock; asynchronous active-high reset
//   start               - level request, sampled only while idle
//   id_proc, trilha     - target process (1..3) and source HD track
//   num_palavras        - words to copy (clamped to the partition size)
//   hd_trilha, hd_setor - HD address; hd_dado - HD read data (combinational)
//   mi_ender, mi_dado   - instruction-memory write address/data
//   InstrWrite          - instruction-memory write strobe
//   busy, done, erro    - status; erro is only meaningful while done = 1
module carregador_programa #(
    parameter int unsigned BASE_MI      = carregador_programa_pkg::BASE_MI,
    parameter int unsigned TAM_PARTICAO = carregador_programa_pkg::TAM_PARTICAO,
    parameter int unsigned MAX_SETOR    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  id_proc,
    input  logic [3:0]  trilha,
    input  logic [5:0]  num_palavras,
    output logic [3:0]  hd_trilha,
    output logic [5:0]  hd_setor,
    input  logic [31:0] hd_dado,
    output logic [8:0]  mi_ender,
    output logic [31:0] mi_dado,
    output logic        InstrWrite,
    output logic        busy,
    output logic        done,
    output logic        erro
);

    import carregador_programa_pkg::*;

    // A load can never run past the partition nor past the end of the track.
    localparam int unsigned N_MAX = (TAM_PARTICAO < MAX_SETOR) ? TAM_PARTICAO : MAX_SETOR;

    estado_t     r_estado, w_estado_prox;
    logic [1:0]  r_id;
    logic [3:0]  r_trilha;
    logic [5:0]  r_n;
    logic [5:0]  r_idx;
    logic [3:0]  r_hd_trilha;
    logic [8:0]  r_mi_ender;
    logic [31:0] r_mi_dado;
    logic        r_instr_write;
    logic        r_busy;
    logic        r_done;
    logic        r_erro;

    logic        w_aceita;
    logic        w_erro_prox;
    logic        w_busy_prox;
    logic [5:0]  w_idx_prox;
    logic [5:0]  w_n_req;
    logic [3:0]  w_trilha_prox;
    logic [8:0]  w_ender;

    soma_endereco_proc #(
        .M            (BASE_MI),
        .tam_particao (TAM_PARTICAO)
    ) u_soma (
        .i_id       (r_id),
        .i_offset   (r_idx),
        .o_endereco (w_ender)
    );

    assign w_n_req = (num_palavras > 6'(N_MAX)) ? 6'(N_MAX) : num_palavras;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_estado <= OCIOSO;
        else       r_estado <= w_estado_prox;
    end

    always_comb begin
        w_estado_prox = r_estado;
        w_aceita      = 1'b0;
        w_erro_prox   = 1'b0;
        w_idx_prox    = r_idx;
        case (r_estado)
            OCIOSO: begin
                if (start) begin
                    w_aceita   = 1'b1;
                    w_idx_prox = '0;
                    if (id_proc == 2'd0) begin
                        w_estado_prox = FIM;
                        w_erro_prox   = 1'b1;
                    end else if (w_n_req == 6'd0) begin
                        w_estado_prox = FIM;
                    end else begin
                        w_estado_prox = ENDERECA;
                    end
                end
            end
            ENDERECA: w_estado_prox = ESCREVE;
            ESCREVE: begin
                if (r_idx == r_n - 6'd1) begin
                    w_estado_prox = FIM;
                end else begin
                    w_idx_prox    = r_idx + 6'd1;
                    w_estado_prox = ENDERECA;
                end
            end
            FIM: w_estado_prox = OCIOSO;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    assign w_busy_prox   = (w_estado_prox == ENDERECA) || (w_estado_prox == ESCREVE);
    assign w_trilha_prox = w_aceita ? trilha : r_trilha;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id          <= '0;
            r_trilha      <= '0;
            r_n           <= '0;
            r_idx         <= '0;
            r_hd_trilha   <= '0;
            r_mi_ender    <= '0;
            r_mi_dado     <= '0;
            r_instr_write <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_erro        <= 1'b0;
        end else begin
            if (w_aceita) begin
                r_id     <= id_proc;
                r_trilha <= trilha;
                r_n      <= w_n_req;
            end
            r_idx         <= w_idx_prox;
            r_busy        <= w_busy_prox;
            r_done        <= (w_estado_prox == FIM);
            r_erro        <= w_erro_prox;
            r_instr_write <= (w_estado_prox == ESCREVE);
            r_hd_trilha   <= w_busy_prox ? w_trilha_prox : '0;
            // HD data for the current sector is settled by the end of
            // ENDERECA; capture it with the address for the ESCREVE cycle.
            if (r_estado == ENDERECA) begin
                r_mi_ender <= w_ender;
                r_mi_dado  <= hd_dado;
            end
        end
    end

    assign hd_setor   = r_idx;
    assign hd_trilha  = r_hd_trilha;
    assign mi_ender   = r_mi_ender;
    assign mi_dado    = r_mi_dado;
    assign InstrWrite = r_instr_write;
    assign busy       = r_busy;
    assign done       = r_done;
    assign erro       = r_erro;

endmodule
